// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM state encoding and the generic step function.
// The step function works on a fixed maximum width; callers zero-extend
// their state/taps and truncate the result back to their own width.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRERUN = 2'd1,
        RUN    = 2'd2,
        LOCK   = 2'd3
    } lfsr_state_e;

    // One LFSR advance: shift left, feed back the parity of the tapped bits.
    // Bits at or above 'width' are cleared so the result fits the caller.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        fb   = ^(state & taps);
        mask = {LFSR_MAX_W{1'b0}};
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return ((state << 1) & mask) | {{(LFSR_MAX_W-1){1'b0}}, fb};
    endfunction

endpackage

// File: rtl/lfsr_keygen_if.sv
// Keystream output handshake between the generator and its consumer.
interface lfsr_keygen_if #(
    parameter int WIDTH = 6
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_core.sv
// LFSR state and taps registers plus the step logic. Shared between the
// encoder- and decoder-side key generators; sequencing is left to the caller.
module lfsr_core #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] taps,
    input  logic [WIDTH-1:0] start,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);
    import lfsr_pkg::*;

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] taps_r;
    logic [WIDTH-1:0] next_s;

    // Combinational next state from the current state and registered taps.
    always_comb begin
        next_s = WIDTH'(lfsr_next(LFSR_MAX_W'(state_r), LFSR_MAX_W'(taps_r), WIDTH));
    end

    // State/taps registers: load has priority over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= {WIDTH{1'b0}};
            taps_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            state_r <= start;
            taps_r  <= taps;
        end else if (advance) begin
            state_r <= next_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;
    assign next  = next_s;

endmodule

// File: rtl/lfsr_keygen.sv
// Keystream generator: sequences an lfsr_core through an optional pre-run,
// serves words over a valid/ready handshake, halts on the all-zero state and
// measures the seed-to-seed period.
module lfsr_keygen #(
    parameter int WIDTH = 6,
    parameter int CNT_W = WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic [WIDTH-1:0]  taps,
    input  logic [WIDTH-1:0]  start,
    input  logic [CNT_W-1:0]  skip,
    lfsr_keygen_if.master     kif,
    output logic              busy,
    output logic              lockup,
    output logic              period_done,
    output logic [CNT_W-1:0]  period
);
    import lfsr_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    lfsr_state_e      fsm_r;
    lfsr_state_e      fsm_nxt_s;
    logic             advance_s;
    logic [WIDTH-1:0] state_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] seed_r;
    logic [CNT_W-1:0] skip_cnt_r;
    logic [CNT_W-1:0] adv_cnt_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             lockup_r;
    logic             period_done_r;
    logic [CNT_W-1:0] period_r;

    lfsr_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (init),
        .advance (advance_s),
        .taps    (taps),
        .start   (start),
        .state   (state_s),
        .next    (next_s)
    );

    // Next-state and advance decode; init overrides everything else.
    always_comb begin
        fsm_nxt_s = fsm_r;
        advance_s = 1'b0;
        if (init) begin
            if (start == {WIDTH{1'b0}}) begin
                fsm_nxt_s = LOCK;
            end else if (skip != {CNT_W{1'b0}}) begin
                fsm_nxt_s = PRERUN;
            end else begin
                fsm_nxt_s = RUN;
            end
        end else begin
            case (fsm_r)
                IDLE: begin
                    fsm_nxt_s = IDLE;
                end
                PRERUN: begin
                    advance_s = 1'b1;
                    if (next_s == {WIDTH{1'b0}}) begin
                        fsm_nxt_s = LOCK;
                    end else if (skip_cnt_r == CNT_ONE) begin
                        fsm_nxt_s = RUN;
                    end else begin
                        fsm_nxt_s = PRERUN;
                    end
                end
                RUN: begin
                    advance_s = kif.out_ready;
                    if (kif.out_ready && (next_s == {WIDTH{1'b0}})) begin
                        fsm_nxt_s = LOCK;
                    end else begin
                        fsm_nxt_s = RUN;
                    end
                end
                LOCK: begin
                    fsm_nxt_s = LOCK;
                end
                default: begin
                    fsm_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            lockup_r    <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            out_valid_r <= (fsm_nxt_s == RUN);
            busy_r      <= (fsm_nxt_s == PRERUN);
            lockup_r    <= (fsm_nxt_s == LOCK);
        end
    end

    // Seed copy, pre-run countdown, advance counter and period capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_r        <= {WIDTH{1'b0}};
            skip_cnt_r    <= {CNT_W{1'b0}};
            adv_cnt_r     <= {CNT_W{1'b0}};
            period_done_r <= 1'b0;
            period_r      <= {CNT_W{1'b0}};
        end else if (init) begin
            seed_r        <= start;
            skip_cnt_r    <= skip;
            adv_cnt_r     <= {CNT_W{1'b0}};
            period_done_r <= 1'b0;
            period_r      <= {CNT_W{1'b0}};
        end else if (advance_s) begin
            if ((fsm_r == PRERUN) && (skip_cnt_r != {CNT_W{1'b0}})) begin
                skip_cnt_r <= skip_cnt_r - CNT_ONE;
            end else begin
                skip_cnt_r <= skip_cnt_r;
            end
            if (adv_cnt_r != CNT_MAX) begin
                adv_cnt_r <= adv_cnt_r + CNT_ONE;
            end else begin
                adv_cnt_r <= adv_cnt_r;
            end
            if ((next_s == seed_r) && !period_done_r) begin
                period_done_r <= 1'b1;
                period_r      <= (adv_cnt_r == CNT_MAX) ? CNT_MAX : (adv_cnt_r + CNT_ONE);
            end else begin
                period_done_r <= period_done_r;
                period_r      <= period_r;
            end
        end else begin
            seed_r        <= seed_r;
            skip_cnt_r    <= skip_cnt_r;
            adv_cnt_r     <= adv_cnt_r;
            period_done_r <= period_done_r;
            period_r      <= period_r;
        end
    end

    assign kif.out_valid = out_valid_r;
    assign kif.out_data  = state_s;
    assign busy          = busy_r;
    assign lockup        = lockup_r;
    assign period_done   = period_done_r;
    assign period        = period_r;

endmodule
